// File: rtl/cpu_pkg.sv
// Shared constants and types for the next-PC unit and its statistics counters.
package cpu_pkg;

  localparam logic [31:0] RESET_PC          = 32'h0000_0000;
  localparam logic [31:0] SYSCALL_HALT_CODE = 32'd10;

  localparam int unsigned CYCLE_CNT_W  = 32;
  localparam int unsigned JUMP_CNT_W   = 16;
  localparam int unsigned BRANCH_CNT_W = 16;

  // One-bit run/halt state.
  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } pc_state_e;

endpackage

// File: rtl/stat_counter.sv
// Free-running statistics counter: counts when inc is set and hold is clear, wraps on overflow.
module stat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             hold,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count register; async clear, wraps to zero naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && !hold) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/next_pc_unit.sv
// Program counter sequencer: branch/jump target selection, syscall halt/display, resume button
// and execution statistics.
module next_pc_unit
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Instr,
  input  logic [31:0] RS_Data,
  input  logic        Equal,
  input  logic        Beq,
  input  logic        Bne,
  input  logic        BLTZ,
  input  logic        JMP,
  input  logic        JAL,
  input  logic        JR,
  input  logic        SysCALL,
  input  logic [31:0] V0_Data,
  input  logic [31:0] A0_Data,
  input  logic        Go,
  output logic [31:0] PC,
  output logic [31:0] PC_Plus4,
  output logic        Halt,
  output logic [31:0] LED_Data,
  output logic [31:0] Cycle_Cnt,
  output logic [15:0] Jump_Cnt,
  output logic [15:0] Branch_Cnt
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] led_q, led_d;
  logic        go_q;

  logic        taken;
  logic        jump_any;
  logic        halt_sys;
  logic        halted;
  logic [31:0] branch_off;
  logic [31:0] jump_target;

  // Opcode bits are decoded upstream; only the target/offset fields matter here.
  logic unused_instr;
  assign unused_instr = ^Instr[31:26];

  assign PC_Plus4 = pc_q + 32'd4;

  // Branch condition, transfer classification and target arithmetic.
  always_comb begin
    taken       = (Beq & Equal) | (Bne & ~Equal) | (BLTZ & RS_Data[31]);
    jump_any    = JMP | JAL | JR;
    halt_sys    = SysCALL && (V0_Data == SYSCALL_HALT_CODE);
    branch_off  = {{14{Instr[15]}}, Instr[15:0], 2'b00};
    jump_target = {PC_Plus4[31:28], Instr[25:0], 2'b00};
  end

  // Next-state, next-PC and display register selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    led_d   = led_q;
    unique case (state_q)
      StRun: begin
        if (JR) begin
          pc_d = RS_Data;
        end else if (JMP || JAL) begin
          pc_d = jump_target;
        end else if (taken) begin
          pc_d = PC_Plus4 + branch_off;
        end else if (halt_sys) begin
          pc_d = pc_q;
        end else begin
          pc_d = PC_Plus4;
        end
        if (halt_sys) begin
          state_d = StHalt;
        end else if (SysCALL) begin
          led_d = A0_Data;
        end
      end
      StHalt: begin
        // Resume on a rising edge of the button, stepping past the halting syscall.
        if (Go && !go_q) begin
          state_d = StRun;
          pc_d    = PC_Plus4;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State, PC, display and button-history registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      led_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      led_q   <= led_d;
      go_q    <= Go;
    end
  end

  assign halted   = (state_q == StHalt);
  assign PC       = pc_q;
  assign Halt     = halted;
  assign LED_Data = led_q;

  stat_counter #(
    .WIDTH (CYCLE_CNT_W)
  ) u_cycle_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (1'b1),
    .hold  (halted),
    .count (Cycle_Cnt)
  );

  stat_counter #(
    .WIDTH (JUMP_CNT_W)
  ) u_jump_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (jump_any),
    .hold  (halted),
    .count (Jump_Cnt)
  );

  // Taken branches that lose to an unconditional transfer are not counted.
  stat_counter #(
    .WIDTH (BRANCH_CNT_W)
  ) u_branch_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (taken & ~jump_any),
    .hold  (halted),
    .count (Branch_Cnt)
  );

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: directed scenarios with literal expectations, then randomized
// instruction streams compared every cycle against a behavioural model.
module tb_next_pc_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] Instr = '0;
  logic [31:0] RS_Data = '0;
  logic        Equal = 1'b0;
  logic        Beq = 1'b0, Bne = 1'b0, BLTZ = 1'b0, JMP = 1'b0, JAL = 1'b0, JR = 1'b0;
  logic        SysCALL = 1'b0;
  logic [31:0] V0_Data = '0;
  logic [31:0] A0_Data = '0;
  logic        Go = 1'b0;
  logic [31:0] PC, PC_Plus4, LED_Data, Cycle_Cnt;
  logic        Halt;
  logic [15:0] Jump_Cnt, Branch_Cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  next_pc_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .Instr      (Instr),
    .RS_Data    (RS_Data),
    .Equal      (Equal),
    .Beq        (Beq),
    .Bne        (Bne),
    .BLTZ       (BLTZ),
    .JMP        (JMP),
    .JAL        (JAL),
    .JR         (JR),
    .SysCALL    (SysCALL),
    .V0_Data    (V0_Data),
    .A0_Data    (A0_Data),
    .Go         (Go),
    .PC         (PC),
    .PC_Plus4   (PC_Plus4),
    .Halt       (Halt),
    .LED_Data   (LED_Data),
    .Cycle_Cnt  (Cycle_Cnt),
    .Jump_Cnt   (Jump_Cnt),
    .Branch_Cnt (Branch_Cnt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_led, m_cyc;
  logic [15:0] m_jmp, m_br;
  bit          m_halt, m_goq;

  function automatic bit ref_taken();
    bit rs_negative;
    rs_negative = $signed(RS_Data) < 0;
    return (Beq && Equal) || (Bne && !Equal) || (BLTZ && rs_negative);
  endfunction

  function automatic logic [31:0] ref_next_pc(input logic [31:0] pc);
    logic [31:0] seq, off;
    seq = pc + 32'd4;
    off = {{16{Instr[15]}}, Instr[15:0]};
    if (JR) return RS_Data;
    if (JMP || JAL) return (seq & 32'hF000_0000) | ({6'd0, Instr[25:0]} * 32'd4);
    if (ref_taken()) return seq + off * 32'd4;
    if (SysCALL && V0_Data == 32'd10) return pc;
    return seq;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pc <= '0; m_led <= '0; m_cyc <= '0; m_jmp <= '0; m_br <= '0;
      m_halt <= 1'b0; m_goq <= 1'b0;
    end else begin
      m_goq <= Go;
      if (!m_halt) begin
        m_pc  <= ref_next_pc(m_pc);
        m_cyc <= m_cyc + 32'd1;
        if (JMP || JAL || JR) m_jmp <= m_jmp + 16'd1;
        else if (ref_taken()) m_br <= m_br + 16'd1;
        if (SysCALL && V0_Data == 32'd10) m_halt <= 1'b1;
        else if (SysCALL) m_led <= A0_Data;
      end else if (Go && !m_goq) begin
        m_halt <= 1'b0;
        m_pc   <= m_pc + 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (cmp_en && !RST) begin
      check("model_pc", PC, m_pc);
      check("model_pc_plus4", PC_Plus4, m_pc + 32'd4);
      check("model_halt", {31'd0, Halt}, {31'd0, m_halt});
      check("model_led", LED_Data, m_led);
      check("model_cycle_cnt", Cycle_Cnt, m_cyc);
      check("model_jump_cnt", {16'd0, Jump_Cnt}, {16'd0, m_jmp});
      check("model_branch_cnt", {16'd0, Branch_Cnt}, {16'd0, m_br});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    Instr = '0; RS_Data = '0; Equal = 1'b0;
    Beq = 1'b0; Bne = 1'b0; BLTZ = 1'b0; JMP = 1'b0; JAL = 1'b0; JR = 1'b0;
    SysCALL = 1'b0; V0_Data = '0; A0_Data = '0;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pc"}, PC, 32'h0);
    check({tag, "_pc_plus4"}, PC_Plus4, 32'h4);
    check({tag, "_halt"}, {31'd0, Halt}, 32'h0);
    check({tag, "_led"}, LED_Data, 32'h0);
    check({tag, "_cycle_cnt"}, Cycle_Cnt, 32'h0);
    check({tag, "_jump_cnt"}, {16'd0, Jump_Cnt}, 32'h0);
    check({tag, "_branch_cnt"}, {16'd0, Branch_Cnt}, 32'h0);
  endtask

  task automatic randomize_inputs();
    int sel;
    idle();
    Instr   = $urandom;
    RS_Data = ($urandom_range(0, 1) == 1) ? $urandom : {24'd0, 8'($urandom_range(0, 255))};
    Equal   = 1'($urandom_range(0, 1));
    sel     = $urandom_range(0, 15);
    case (sel)
      0: Beq = 1'b1;
      1: Bne = 1'b1;
      2: BLTZ = 1'b1;
      3: JMP = 1'b1;
      4: JAL = 1'b1;
      5: JR = 1'b1;
      6: SysCALL = 1'b1;
      15: {Beq, Bne, BLTZ, JMP, JAL, JR, SysCALL} = 7'($urandom);
      default: ;
    endcase
    V0_Data = ($urandom_range(0, 1) == 1) ? 32'd10 : $urandom_range(0, 40);
    A0_Data = $urandom;
    Go      = ($urandom_range(0, 9) < 3);
  endtask

  initial begin
    idle();
    #2;
    check_zero("reset_initial");
    @(negedge CLK);
    RST = 1'b0;
    cmp_en = 1'b1;

    // Sequential fetch from reset.
    check("seq_pc0", PC, 32'h0);
    tick(); check("seq_pc1", PC, 32'h4);
    tick(); check("seq_pc2", PC, 32'h8);
    tick(); check("seq_pc3", PC, 32'hC);
    check("seq_cycle_cnt", Cycle_Cnt, 32'd3);
    tick(); check("seq_pc4", PC, 32'h10);

    // Backward taken branch, then not-taken at the same PC.
    Beq = 1'b1; Equal = 1'b1; Instr = 32'h0000_FFFC;
    tick(); check("beq_taken_pc", PC, 32'h4);
    check("beq_taken_cnt", {16'd0, Branch_Cnt}, 32'd1);
    idle();
    tick(); tick(); tick(); check("beq_return_pc", PC, 32'h10);
    Beq = 1'b1; Equal = 1'b0; Instr = 32'h0000_FFFC;
    tick(); check("beq_not_taken_pc", PC, 32'h14);
    check("beq_not_taken_cnt", {16'd0, Branch_Cnt}, 32'd1);

    // Jumps.
    idle(); JR = 1'b1; RS_Data = 32'h0040_0020;
    tick(); check("jr_far_pc", PC, 32'h0040_0020);
    idle(); JAL = 1'b1; Instr = 32'h0000_0040;
    tick(); check("jal_pc", PC, 32'h0000_0100);
    check("jal_jump_cnt", {16'd0, Jump_Cnt}, 32'd2);
    idle(); JR = 1'b1; RS_Data = 32'h24;
    tick(); check("jr_pc", PC, 32'h24);
    check("jr_jump_cnt", {16'd0, Jump_Cnt}, 32'd3);

    // Display syscall, then halt syscall at 0x30.
    idle();
    tick(); tick(); check("pre_sys_pc", PC, 32'h2C);
    SysCALL = 1'b1; V0_Data = 32'd34; A0_Data = 32'h1234;
    tick(); check("sys_led", LED_Data, 32'h1234);
    check("sys_pc", PC, 32'h30);
    V0_Data = 32'd10; A0_Data = 32'hDEAD;
    tick(); check("halt_flag", {31'd0, Halt}, 32'd1);
    check("halt_led_kept", LED_Data, 32'h1234);
    for (int i = 0; i < 5; i++) begin
      idle(); JR = 1'b1; Beq = 1'b1; Equal = 1'b1; RS_Data = 32'h8000_0000;
      SysCALL = 1'b1; A0_Data = 32'hBEEF;
      tick();
      check("halt_pc_hold", PC, 32'h30);
      check("halt_cycle_hold", Cycle_Cnt, 32'd16);
      check("halt_jump_hold", {16'd0, Jump_Cnt}, 32'd3);
      check("halt_branch_hold", {16'd0, Branch_Cnt}, 32'd1);
      check("halt_led_hold", LED_Data, 32'h1234);
    end
    idle(); Go = 1'b1;
    tick(); check("resume_halt", {31'd0, Halt}, 32'd0);
    check("resume_pc", PC, 32'h34);
    check("resume_cycle_cnt", Cycle_Cnt, 32'd16);
    Go = 1'b0;

    // Halt again, then async reset with Go held high.
    SysCALL = 1'b1; V0_Data = 32'd10;
    tick(); check("halt2_flag", {31'd0, Halt}, 32'd1);
    idle(); Go = 1'b1;
    tick();
    #2 RST = 1'b1;
    #1 check_zero("reset_async");
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    check("post_reset_pc", PC, 32'h4);
    check("post_reset_no_resume", {31'd0, Halt}, 32'd0);
    tick(); check("post_reset_pc2", PC, 32'h8);
    Go = 1'b0;

    // Randomized streams with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2 RST = 1'b1;
        #1 check_zero("reset_random");
        @(negedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
      end
      randomize_inputs();
      tick();
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 CLK  in  1  single system clock; all state updates on its rising edge.
REQ-002 RST  in  1  reset, asynchronous, active-high.
REQ-003 Instr  in  32  current instruction word; [25:0] jump target, [15:0] branch offset.
REQ-004 RS_Data  in  32  register-file rs read value; JR target and BLTZ sign source.
REQ-005 Equal  in  1  ALU equality flag, rs == rt.
REQ-006 Beq, Bne, BLTZ, JMP, JAL, JR, SysCALL  in  1 each  decoded control strobes from the control decoder.
REQ-007 V0_Data  in  32  register $v0 value, the syscall function code.
REQ-008 A0_Data  in  32  register $a0 value, the syscall display argument.
REQ-009 Go  in  1  resume request from the board button; level input, rising edge acts.
REQ-010 PC  out  32  current instruction address; instruction-ROM address.
REQ-011 PC_Plus4  out  32  PC+4, combinational; JAL link value.
REQ-012 Halt  out  1  high while in HALT state.
REQ-013 LED_Data  out  32  last displayed syscall argument.
REQ-014 Cycle_Cnt  out  32  executed-cycle count.
REQ-015 Jump_Cnt  out  16  unconditional-transfer count.
REQ-016 Branch_Cnt  out  16  taken-conditional-branch count.

Function
REQ-017 States SHALL be RUN and HALT, encoded as a 1-bit register.
REQ-018 Taken SHALL equal (Beq&Equal) | (Bne&~Equal) | (BLTZ&RS_Data[31]).
REQ-019 In RUN, the next PC SHALL use this priority: JR -> RS_Data; JMP|JAL -> {PC_Plus4[31:28], Instr[25:0], 2'b00}; Taken -> PC_Plus4 + (sign-extended Instr[15:0] << 2); HaltSys -> PC unchanged; otherwise PC_Plus4.
REQ-020 HaltSys SHALL equal SysCALL & (V0_Data == SYSCALL_HALT_CODE, 10); in RUN it SHALL set the state to HALT on the next edge.
REQ-021 SysCALL with V0_Data != 10 SHALL load LED_Data <= A0_Data on the edge and advance to PC_Plus4.
REQ-022 All address arithmetic SHALL be modulo 2^32, wrapping silently with no flag.
REQ-023 Cycle_Cnt SHALL increment on every RUN cycle, including the cycle that enters HALT.
REQ-024 Jump_Cnt SHALL increment on each RUN cycle with JMP|JAL|JR set.
REQ-025 Branch_Cnt SHALL increment on each RUN cycle with Taken=1 and no JR/JMP/JAL set.
REQ-026 All counters SHALL wrap to 0 on overflow.
REQ-027 In HALT, PC, LED_Data and all counters SHALL hold.
REQ-028 In HALT, a Go rising edge (Go=1 and registered Go_q=0) SHALL return the state to RUN and set PC <= PC_Plus4 on the same edge.
REQ-029 Go edges in RUN SHALL be ignored; Go_q SHALL be sampled every cycle in both states.
REQ-030 Latency: the PC update SHALL take effect exactly one edge after its inputs; no pipelining.

Reset
REQ-031 RST high SHALL immediately force PC=RESET_PC (0x00000000), state=RUN, Halt=0, LED_Data=0, all counters=0, Go_q=0, independent of CLK.
REQ-032 Reset asserted mid-operation or in HALT SHALL discard all state; the first edge after deassertion SHALL execute the instruction at 0.

Structure
REQ-033 Package cpu_pkg SHALL hold RESET_PC, SYSCALL_HALT_CODE, and the 32/16 counter widths.
REQ-034 The three counters SHALL be instances of one sub-module, stat_counter, with parameters WIDTH and async reset, and inputs inc and hold.
REQ-035 The next-PC multiplexer and the Taken logic SHALL be combinational inside next_pc_unit.

Verification
REQ-036 Reset, then 3 plain cycles -> PC sequence 0, 4, 8, 0xC; Cycle_Cnt=3.
REQ-037 PC=0x10, Beq=1, Equal=1, Instr[15:0]=0xFFFC -> next PC=0x04; Branch_Cnt+1; repeat with Equal=0 -> PC=0x14, counter unchanged.
REQ-038 PC=0x00400020, JAL=1, Instr[25:0]=0x0000040 -> PC=0x00000100, Jump_Cnt+1; then JR=1, RS_Data=0x24 -> PC=0x24.
REQ-039 SysCALL=1, V0=34, A0=0x1234 -> LED_Data=0x1234, PC advances; then SysCALL=1, V0=10 at PC=0x30 -> Halt=1, PC stays 0x30 for 5 cycles, counters frozen; Go pulse -> Halt=0, PC=0x34.
REQ-040 Assert RST asynchronously while Halt=1 with non-zero counters -> all outputs zero before the next CLK edge; Go held high through reset produces no resume.
